// File: rtl/regfile_mp_if.sv
// Bus bundle for the 2-read/1-write register file: write port, two read ports,
// and the bulk-clear handshake.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              reg_write;
    logic [ADDR_W-1:0] write_register;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_reg_1;
    logic [ADDR_W-1:0] read_reg_2;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic              clear_req;
    logic              clear_busy;
    logic              write_ok;

    modport master (
        output reg_write, write_register, write_data,
        output read_reg_1, read_reg_2, clear_req,
        input  read_data_1, read_data_2, clear_busy, write_ok
    );

    modport slave (
        input  reg_write, write_register, write_data,
        input  read_reg_1, read_reg_2, clear_req,
        output read_data_1, read_data_2, clear_busy, write_ok
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised 2-read/1-write register file with optional zero register,
// write-to-read bypass and a sequenced bulk-clear sweep.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              busy;
    logic              w_ok;
    logic [DATA_W-1:0] rf [DEPTH];
    logic [DATA_W-1:0] rd1, rd2;

    // An address names real storage only if it is below DEPTH and is not the
    // hard-wired zero register.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W+1)'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clear_req) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end
            end
            SWEEP: begin
                busy    = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
        endcase
    end

    // rst_n gates acceptance so neither a write nor a bypass leaks out during reset.
    assign w_ok = rst_n & bus.reg_write & ~busy & addr_legal(bus.write_register);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy && (cnt == ADDR_W'(i)))
                    rf[i] <= '0;
                else if (w_ok && (bus.write_register == ADDR_W'(i)))
                    rf[i] <= bus.write_data;
            end
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.read_reg_1 == ADDR_W'(i)) rd1 = rf[i];
            if (bus.read_reg_2 == ADDR_W'(i)) rd2 = rf[i];
        end
        if (busy || !addr_legal(bus.read_reg_1)) rd1 = '0;
        if (busy || !addr_legal(bus.read_reg_2)) rd2 = '0;
        // w_ok already excludes dropped writes, so forwarding never exposes them.
        if ((BYPASS != 0) && w_ok && (bus.write_register == bus.read_reg_1)) rd1 = bus.write_data;
        if ((BYPASS != 0) && w_ok && (bus.write_register == bus.read_reg_2)) rd2 = bus.write_data;
    end

    assign bus.read_data_1 = rd1;
    assign bus.read_data_2 = rd2;
    assign bus.clear_busy  = busy;
    assign bus.write_ok    = w_ok;

endmodule
